// File: rtl/johnson_decoder_checker_pkg.sv
// Shared types and helpers for Johnson-code consumers.
// Holds the checker states and the index-to-code generator.
package johnson_decoder_checker_pkg;

  localparam int MAXW = 32;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Code for index idx in a width-stage shift-left, ~msb feedback ring.
  function automatic logic [MAXW-1:0] code_of(
    input int idx,
    input int width
  );
    logic [MAXW-1:0] c;
    c = '0;
    for (int b = 0; b < MAXW; b++) begin
      if (b < width) begin
        if (idx <= width) c[b] = (b < idx);
        else              c[b] = (b >= idx - width);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/johnson_decoder_checker_decode.sv
// Combinational Johnson decoder: code -> {index, legal}.
// Legality is a recompute-and-compare against the decoded index.
module johnson_code_decode
  import johnson_decoder_checker_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]           q,
  output logic [$clog2(2*WIDTH)-1:0] idx,
  output logic                       legal
);

  localparam int IW = $clog2(2*WIDTH);

  int              pc;
  int              raw;
  logic [MAXW-1:0] ref_c;

  always_comb begin
    pc = 0;
    for (int b = 0; b < WIDTH; b++) begin
      pc = pc + int'(q[b]);
    end
    raw   = q[WIDTH-1] ? (2*WIDTH - pc) : pc;
    ref_c = code_of(raw, WIDTH);
    legal = (q == ref_c[WIDTH-1:0]);
    idx   = legal ? IW'(raw) : '0;
  end

endmodule

// File: rtl/johnson_decoder_checker.sv
// Johnson-code integrity monitor: decode, lock tracking,
// sequence-error detection and a saturating error counter.
module johnson_decoder_checker
  import johnson_decoder_checker_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           q_in,
  input  logic                       q_valid,
  input  logic                       err_clr,
  output logic [$clog2(2*WIDTH)-1:0] idx,
  output logic                       idx_valid,
  output logic                       illegal,
  output logic                       seq_err,
  output logic                       locked,
  output logic [ERR_W-1:0]           err_cnt
);

  localparam int IW = $clog2(2*WIDTH);
  localparam int MW = $clog2(LOCK_N+1);
  localparam logic [IW-1:0] LAST = IW'(2*WIDTH-1);
  localparam logic [ERR_W-1:0] SAT = {ERR_W{1'b1}};

  state_t          state, state_n;
  logic [IW-1:0]   prev, prev_n;
  logic [MW-1:0]   match, match_n;
  logic [IW-1:0]   idx_n;
  logic            idxv_n;
  logic            ill_n;
  logic            seq_n;
  logic [ERR_W-1:0] err_n;

  logic [IW-1:0]   d_idx;
  logic            d_legal;
  logic [IW-1:0]   succ_idx;
  logic            succ;

  johnson_code_decode #(
    .WIDTH (WIDTH)
  ) u_dec (
    .q     (q_in),
    .idx   (d_idx),
    .legal (d_legal)
  );

  // Wrap N-1 -> 0 explicitly; N need not be a power of two.
  assign succ_idx = (prev == LAST) ? '0 : prev + 1'b1;
  assign succ     = (d_idx == succ_idx);

  always_comb begin
    state_n = state;
    prev_n  = prev;
    match_n = match;
    idx_n   = idx;
    idxv_n  = 1'b0;
    ill_n   = 1'b0;
    seq_n   = 1'b0;
    if (q_valid) begin
      if (!d_legal) begin
        ill_n   = 1'b1;
        idx_n   = '0;
        match_n = '0;
        state_n = UNLOCKED;
      end else begin
        idx_n  = d_idx;
        idxv_n = 1'b1;
        prev_n = d_idx;
        unique case (state)
          UNLOCKED: begin
            state_n = ACQUIRE;
            match_n = '0;
          end
          ACQUIRE: begin
            if (succ) begin
              match_n = match + 1'b1;
              if (match_n == MW'(LOCK_N)) state_n = LOCKED;
            end else begin
              match_n = '0;
            end
          end
          LOCKED: begin
            if (!succ) begin
              state_n = ACQUIRE;
              match_n = '0;
              seq_n   = 1'b1;
            end
          end
          default: begin
            state_n = UNLOCKED;
            match_n = '0;
          end
        endcase
      end
    end
  end

  // Clear wins over a same-cycle error event.
  always_comb begin
    err_n = err_cnt;
    if (err_clr)                          err_n = '0;
    else if ((ill_n | seq_n) && err_cnt != SAT) err_n = err_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= UNLOCKED;
      prev      <= '0;
      match     <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      match     <= match_n;
      idx       <= idx_n;
      idx_valid <= idxv_n;
      illegal   <= ill_n;
      seq_err   <= seq_n;
      err_cnt   <= err_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Directed bench for johnson_decoder_checker (WIDTH=4, LOCK_N=3, ERR_W=8).
`timescale 1ns/1ps
module tb_johnson_decoder_checker;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] q_in = 4'b0000;
  logic       q_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] idx;
  logic       idx_valid;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_cnt;

  int total = 0;
  int bad = 0;

  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  johnson_decoder_checker #(
    .WIDTH  (4),
    .LOCK_N (3),
    .ERR_W  (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .q_in      (q_in),
    .q_valid   (q_valid),
    .err_clr   (err_clr),
    .idx       (idx),
    .idx_valid (idx_valid),
    .illegal   (illegal),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic v, input logic clr);
    @(negedge clk);
    q_in    = c;
    q_valid = v;
    err_clr = clr;
    @(posedge clk);
    #1;
    q_valid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic chk_leg(input string tag, input int ei, input logic el,
                         input logic es);
    chk({tag, ".idx"}, 32'(idx), 32'(ei));
    chk({tag, ".vld"}, 32'(idx_valid), 32'd1);
    chk({tag, ".ill"}, 32'(illegal), 32'd0);
    chk({tag, ".seq"}, 32'(seq_err), 32'(es));
    chk({tag, ".lock"}, 32'(locked), 32'(el));
  endtask

  initial begin
    #2;
    chk("rst.idx", 32'(idx), 0);
    chk("rst.vld", 32'(idx_valid), 0);
    chk("rst.lock", 32'(locked), 0);
    chk("rst.err", 32'(err_cnt), 0);
    #10 reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(codes[i % 8], 1'b1, 1'b0);
      chk_leg("t1", i % 8, (i >= 3), 1'b0);
    end
    chk("t1.err", 32'(err_cnt), 0);

    step(4'b0101, 1'b1, 1'b0);
    chk("t2.ill", 32'(illegal), 1);
    chk("t2.vld", 32'(idx_valid), 0);
    chk("t2.idx", 32'(idx), 0);
    chk("t2.lock", 32'(locked), 0);
    chk("t2.err", 32'(err_cnt), 1);
    step(4'b0000, 1'b0, 1'b0);
    chk("t2.ill_off", 32'(illegal), 0);
    chk("t2.vld_off", 32'(idx_valid), 0);
    step(4'b0000, 1'b1, 1'b0);
    chk_leg("t2.acq", 0, 1'b0, 1'b0);

    step(4'b1100, 1'b1, 1'b0);
    chk_leg("t3.jump", 6, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    chk_leg("t3.m1", 7, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk_leg("t3.m2", 0, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    chk_leg("t3.m3", 1, 1'b1, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    chk_leg("t3.at2", 2, 1'b1, 1'b0);
    step(4'b1110, 1'b1, 1'b0);
    chk_leg("t3.skip", 5, 1'b0, 1'b1);
    chk("t3.err", 32'(err_cnt), 2);
    step(4'b1100, 1'b1, 1'b0);
    chk_leg("t3.r1", 6, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    chk_leg("t3.r2", 7, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk_leg("t3.r3", 0, 1'b1, 1'b0);

    for (int i = 1; i < 8; i++) step(codes[i], 1'b1, 1'b0);
    chk_leg("t4.at7", 7, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk_leg("t4.wrap", 0, 1'b1, 1'b0);
    chk("t4.err0", 32'(err_cnt), 2);
    step(4'b0000, 1'b1, 1'b0);
    chk_leg("t4.rep", 0, 1'b0, 1'b1);
    chk("t4.err", 32'(err_cnt), 3);

    for (int i = 0; i < 260; i++) begin
      step(4'b0101, 1'b1, 1'b0);
      if (i == 250) chk("t5.254", 32'(err_cnt), 254);
    end
    chk("t5.sat", 32'(err_cnt), 255);
    chk("t5.ill", 32'(illegal), 1);
    step(4'b0000, 1'b0, 1'b1);
    chk("t5.clr", 32'(err_cnt), 0);
    step(4'b1001, 1'b1, 1'b0);
    chk("t5.inc", 32'(err_cnt), 1);
    step(4'b1001, 1'b1, 1'b1);
    chk("t5.clrpri", 32'(err_cnt), 0);
    chk("t5.clrill", 32'(illegal), 1);

    for (int i = 0; i < 4; i++) step(codes[i], 1'b1, 1'b0);
    chk_leg("t6.lock", 3, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("t6.err1", 32'(err_cnt), 0);
    step(4'b1010, 1'b1, 1'b0);
    chk("t6.err2", 32'(err_cnt), 1);
    for (int i = 0; i < 4; i++) step(codes[i], 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6.idx", 32'(idx), 0);
    chk("t6.vld", 32'(idx_valid), 0);
    chk("t6.lock0", 32'(locked), 0);
    chk("t6.err", 32'(err_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b0011, 1'b1, 1'b0);
    chk_leg("t6.acq", 2, 1'b0, 1'b0);
    step(4'b0111, 1'b1, 1'b0);
    chk_leg("t6.m1", 3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
